// File: rtl/dfe_pkg.sv
// Shared types and helpers for the one-tap decision-feedback equalizer receive path.
package dfe_pkg;
    localparam int TAP_W    = 3;
    localparam int SAMPLE_W = 8;

    localparam logic signed [TAP_W-1:0] TAP_MAX = 3'sb011;
    localparam logic signed [TAP_W-1:0] TAP_MIN = 3'sb100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } dfe_state_e;

    function automatic logic signed [SAMPLE_W-1:0] sat8(input logic signed [9:0] x);
        logic signed [SAMPLE_W-1:0] y;
        if (x > 10'sd127) begin
            y = 8'sd127;
        end else if (x < -10'sd128) begin
            y = -8'sd128;
        end else begin
            y = x[SAMPLE_W-1:0];
        end
        return y;
    endfunction
endpackage

// File: rtl/dfe_rx_tap_adapt.sv
// Sign-sign LMS adaptation of the single feedback tap over fixed-length sample windows.
module tap_adapt
    import dfe_pkg::*;
#(
    parameter int ACC_LOG = 4,
    parameter int THR     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic signed [1:0]       i_step,
    input  logic                    i_clear,
    output logic signed [TAP_W-1:0] o_tap,
    output logic                    o_win_end,
    output logic                    o_changed
);
    localparam int ACC_W = ACC_LOG + 2;
    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THR);
    localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

    logic signed [ACC_W-1:0]   r_acc;
    logic        [ACC_LOG-1:0] r_cnt;
    logic signed [TAP_W-1:0]   r_tap;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [TAP_W-1:0]   w_tap_next;
    logic                      w_win_end;

    // Window close decision; a step blocked by saturation leaves the tap unchanged
    always_comb begin
        w_acc_next = r_acc + {{ACC_LOG{i_step[1]}}, i_step};
        w_win_end  = i_valid && (r_cnt == {ACC_LOG{1'b1}});
        w_tap_next = r_tap;
        if (w_win_end && (w_acc_next > THR_P) && (r_tap != TAP_MAX)) begin
            w_tap_next = r_tap + 3'sd1;
        end else if (w_win_end && (w_acc_next < THR_N) && (r_tap != TAP_MIN)) begin
            w_tap_next = r_tap - 3'sd1;
        end else begin
            w_tap_next = r_tap;
        end
    end

    // Accumulator, window counter and tap register advance only on valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_tap <= '0;
        end else if (i_valid) begin
            r_cnt <= r_cnt + ACC_LOG'(1);
            r_tap <= w_tap_next;
            if (w_win_end || i_clear) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign o_tap     = r_tap;
    assign o_win_end = w_win_end;
    assign o_changed = w_win_end && (w_tap_next != r_tap);
endmodule

// File: rtl/dfe_rx.sv
// One-tap DFE receiver: feedback cancellation, slicer, training/tracking/lock control and error count.
module dfe_rx
    import dfe_pkg::*;
#(
    parameter int TAP_SHIFT    = 3,
    parameter int REF          = 64,
    parameter int ACC_LOG      = 4,
    parameter int THR          = 4,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  din,
    input  logic        train_en,
    input  logic        train_bit,
    output logic        dout_valid,
    output logic        bit_out,
    output logic [7:0]  eq_out,
    output logic [2:0]  tap_out,
    output logic        locked,
    output logic [15:0] err_cnt
);
    localparam int STB_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic signed [9:0] REF_P = 10'(REF);
    localparam logic signed [9:0] REF_N = -REF_P;

    logic signed [TAP_W-1:0]    w_tap;
    logic signed [9:0]          w_din_x;
    logic signed [9:0]          w_fb;
    logic signed [9:0]          w_sum;
    logic signed [9:0]          w_eq_x;
    logic signed [9:0]          w_err;
    logic signed [SAMPLE_W-1:0] w_eq;
    logic signed [1:0]          w_sgn;
    logic signed [1:0]          w_step;
    logic                       w_dec;
    logic                       w_ref_bit;
    logic                       w_clear;
    logic                       w_win_end;
    logic                       w_changed;
    dfe_state_e                 w_mode;
    dfe_state_e                 r_state;
    logic [STB_W-1:0]           r_stable;
    logic                       r_prev_dec;

    // Cancel post-cursor ISI, slice, and take the sign of the error against the ideal level
    always_comb begin
        w_din_x   = {{2{din[7]}}, din};
        w_fb      = {{7{w_tap[TAP_W-1]}}, w_tap} <<< TAP_SHIFT;
        if (r_prev_dec) begin
            w_sum = w_din_x - w_fb;
        end else begin
            w_sum = w_din_x + w_fb;
        end
        w_eq      = sat8(w_sum);
        w_dec     = ~w_eq[SAMPLE_W-1];
        w_ref_bit = train_en ? train_bit : w_dec;
        w_eq_x    = {{2{w_eq[SAMPLE_W-1]}}, w_eq};
        w_err     = w_eq_x - (w_ref_bit ? REF_P : REF_N);
        if (w_err == 10'sd0) begin
            w_sgn = 2'sd0;
        end else if (w_err[9]) begin
            w_sgn = 2'sb11;
        end else begin
            w_sgn = 2'sd1;
        end
        w_step = r_prev_dec ? w_sgn : -w_sgn;
    end

    // Mode that governs the current sample: a train_en change applies to this very sample
    always_comb begin
        w_mode  = r_state;
        w_clear = 1'b0;
        if (train_en) begin
            w_mode  = ST_TRAIN;
            w_clear = (r_state == ST_TRACK) || (r_state == ST_LOCKED);
        end else if ((r_state == ST_IDLE) || (r_state == ST_TRAIN)) begin
            w_mode = ST_TRACK;
        end else begin
            w_mode = r_state;
        end
    end

    tap_adapt #(
        .ACC_LOG (ACC_LOG),
        .THR     (THR)
    ) u_tap_adapt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (in_valid),
        .i_step    (w_step),
        .i_clear   (w_clear),
        .o_tap     (w_tap),
        .o_win_end (w_win_end),
        .o_changed (w_changed)
    );

    // Control FSM with stable-window counting and registered lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_stable <= '0;
            locked   <= 1'b0;
        end else if (in_valid) begin
            case (w_mode)
                ST_TRAIN: begin
                    r_state  <= ST_TRAIN;
                    r_stable <= '0;
                    locked   <= 1'b0;
                end
                ST_TRACK: begin
                    if (w_win_end && w_changed) begin
                        r_state  <= ST_TRACK;
                        r_stable <= '0;
                        locked   <= 1'b0;
                    end else if (w_win_end) begin
                        r_stable <= r_stable + STB_W'(1);
                        if ((r_stable + STB_W'(1)) == STB_W'(LOCK_WINDOWS)) begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            r_state <= ST_TRACK;
                            locked  <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_TRACK;
                        locked  <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (w_win_end && w_changed) begin
                        r_state  <= ST_TRACK;
                        r_stable <= '0;
                        locked   <= 1'b0;
                    end else begin
                        r_state <= ST_LOCKED;
                        locked  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_stable <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // Output sample registers, decision history and training error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            bit_out    <= 1'b0;
            eq_out     <= 8'd0;
            err_cnt    <= 16'd0;
            r_prev_dec <= 1'b0;
        end else begin
            dout_valid <= in_valid;
            if (in_valid) begin
                r_prev_dec <= w_ref_bit;
                eq_out     <= w_eq;
                bit_out    <= w_dec;
                if (train_en && (w_dec != train_bit) && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

    assign tap_out = w_tap;
endmodule

// File: tb/tb_dfe_rx.sv
// Randomized self-checking bench for dfe_rx against an arithmetic reference model.
module tb_dfe_rx;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [7:0]  din       = 8'd0;
    logic        train_en  = 1'b0;
    logic        train_bit = 1'b0;
    logic        dout_valid;
    logic        bit_out;
    logic [7:0]  eq_out;
    logic [2:0]  tap_out;
    logic        locked;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    localparam int MD_IDLE   = 0;
    localparam int MD_TRAIN  = 1;
    localparam int MD_TRACK  = 2;
    localparam int MD_LOCKED = 3;

    int m_tap, m_acc, m_cnt, m_prev, m_mode, m_stable, m_err;
    logic        exp_dv, exp_bit, exp_locked;
    logic [7:0]  exp_eq;
    logic [2:0]  exp_tap;
    logic [15:0] exp_err;

    wire [29:0] obs  = {dout_valid, bit_out, eq_out, tap_out, locked, err_cnt};
    wire [29:0] expv = {exp_dv, exp_bit, exp_eq, exp_tap, exp_locked, exp_err};

    always #5 clk = ~clk;

    dfe_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .din        (din),
        .train_en   (train_en),
        .train_bit  (train_bit),
        .dout_valid (dout_valid),
        .bit_out    (bit_out),
        .eq_out     (eq_out),
        .tap_out    (tap_out),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    function automatic int sym(input bit b);
        return b ? 1 : -1;
    endfunction

    function automatic void model_reset();
        m_tap = 0; m_acc = 0; m_cnt = 0; m_prev = -1;
        m_mode = MD_IDLE; m_stable = 0; m_err = 0;
        exp_dv = 1'b0; exp_bit = 1'b0; exp_eq = 8'd0;
        exp_tap = 3'd0; exp_locked = 1'b0; exp_err = 16'd0;
    endfunction

    function automatic void model_step(input int d, input bit t, input bit tb);
        int eq, e, sg, mode, nt;
        bit dec, rb, clr;
        eq = d - m_prev * m_tap * 8;
        if (eq > 127) eq = 127;
        else if (eq < -128) eq = -128;
        dec = (eq >= 0);
        rb  = t ? tb : dec;
        e   = eq - (rb ? 64 : -64);
        sg  = (e > 0) ? 1 : ((e < 0) ? -1 : 0);
        m_acc += sg * m_prev;
        if (t && (dec != tb) && (m_err < 65535)) m_err++;
        clr = t && (m_mode == MD_TRACK || m_mode == MD_LOCKED);
        if (t) mode = MD_TRAIN;
        else if (m_mode == MD_IDLE || m_mode == MD_TRAIN) mode = MD_TRACK;
        else mode = m_mode;
        m_cnt++;
        if (m_cnt == 16) begin
            m_cnt = 0;
            nt = m_tap;
            if (m_acc > 4) nt = (m_tap < 3) ? m_tap + 1 : 3;
            else if (m_acc < -4) nt = (m_tap > -4) ? m_tap - 1 : -4;
            if (mode == MD_TRACK) begin
                if (nt != m_tap) m_stable = 0;
                else begin
                    m_stable++;
                    if (m_stable == 4) mode = MD_LOCKED;
                end
            end else if (mode == MD_LOCKED && nt != m_tap) begin
                mode = MD_TRACK;
                m_stable = 0;
            end
            m_tap = nt;
            m_acc = 0;
        end
        if (clr) m_acc = 0;
        if (mode == MD_TRAIN) m_stable = 0;
        m_mode = mode;
        m_prev = rb ? 1 : -1;
        exp_dv = 1'b1; exp_bit = dec; exp_eq = 8'(eq); exp_tap = 3'(m_tap);
        exp_locked = (mode == MD_LOCKED); exp_err = 16'(m_err);
    endfunction

    task automatic drive(input bit v, input int d, input bit t, input bit tb);
        in_valid = v; din = 8'(d); train_en = t; train_bit = tb;
        @(posedge clk);
        if (v) model_step(d, t, tb);
        else exp_dv = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bit b;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 30'd0) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", obs, 30'd0);
        end
        in_valid = 1'b0; train_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        b = 1'($urandom_range(0, 1));
        drive(1'b1, sym(b) * 64, 1'b0, 1'b0);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL reset_first: got %h expected %h", obs, expv);
        end
    endtask

    task automatic test_clean();
        for (int i = 0; i < 63; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            drive(1'b1, sym(b) * 64, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL clean[%0d]: got %h expected %h", i, obs, expv);
            end
            checks++;
            if (bit_out !== b) begin
                failures++;
                $display("FAIL clean_bit[%0d]: got %0b expected %0b", i, bit_out, b);
            end
            // sample 64 since reset closes the fourth stable window
            if (i == 61) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++;
                    $display("FAIL clean_prelock: got %0b expected 0", locked);
                end
            end
            if (i == 62) begin
                checks++;
                if (locked !== 1'b1 || tap_out !== 3'd0) begin
                    failures++;
                    $display("FAIL clean_lock: got locked=%0b tap=%0d expected 1/0", locked, tap_out);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        bit b;
        b = 1'($urandom_range(0, 1));
        drive(1'b1, sym(b) * 64, 1'b1, b);
        checks++;
        if (locked !== 1'b0 || obs !== expv) begin
            failures++;
            $display("FAIL train_pulse: got %h expected %h", obs, expv);
        end
        for (int i = 0; i < 60; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            drive(v, sym(b) * 64, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL gaps[%0d]: got %h expected %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_isi();
        bit sp;
        sp = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            drive(1'b1, 48 * sym(s) + 16 * sym(sp), (i < 256), s);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL isi[%0d]: got %h expected %h", i, obs, expv);
            end
            sp = s;
        end
    endtask

    task automatic test_train_mismatch();
        for (int i = 0; i < 30; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            drive(1'b1, sym(s) * 64, 1'b1, (i < 10) ? ~s : s);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL mismatch[%0d]: got %h expected %h", i, obs, expv);
            end
        end
        checks++;
        if (err_cnt !== 16'd10) begin
            failures++;
            $display("FAIL mismatch_count: got %0d expected 10", err_cnt);
        end
    endtask

    task automatic test_sat_pos();
        bit sp;
        sp = 1'b0;
        for (int i = 0; i < 128; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            drive(1'b1, 48 * sym(s) + 40 * sym(sp), 1'b1, s);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL sat_pos[%0d]: got %h expected %h", i, obs, expv);
            end
            sp = s;
        end
        checks++;
        if (tap_out !== 3'd3) begin
            failures++;
            $display("FAIL sat_pos_tap: got %0d expected 3", tap_out);
        end
        drive(1'b1, 48 + 40 * sym(sp), 1'b1, 1'b1);
        drive(1'b1, -128, 1'b1, 1'b0);
        checks++;
        if (eq_out !== 8'h80 || obs !== expv) begin
            failures++;
            $display("FAIL clamp: got eq=%h all=%h expected eq=80 all=%h", eq_out, obs, expv);
        end
        sp = 1'b0;
        for (int i = 0; i < 96; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            drive(1'b1, 48 * sym(s) + 40 * sym(sp), 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL sat_pos_track[%0d]: got %h expected %h", i, obs, expv);
            end
            sp = s;
        end
        checks++;
        if (tap_out !== 3'd3 || locked !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos_lock: got tap=%0d locked=%0b expected 3/1", tap_out, locked);
        end
    endtask

    task automatic test_sat_neg();
        bit sp;
        sp = 1'b1;
        for (int i = 0; i < 208; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            drive(1'b1, 64 * sym(s) - 48 * sym(sp), (i < 128), s);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL sat_neg[%0d]: got %h expected %h", i, obs, expv);
            end
            if (i == 127) begin
                checks++;
                if (tap_out !== 3'b100) begin
                    failures++;
                    $display("FAIL sat_neg_tap: got %0d expected 4 (=-4)", tap_out);
                end
            end
            sp = s;
        end
        checks++;
        if (tap_out !== 3'b100 || locked !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg_lock: got tap=%0d locked=%0b expected 4/1", tap_out, locked);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_clean();
        test_mode_switch();
        test_isi();
        test_reset();
        test_train_mismatch();
        test_reset();
        test_sat_pos();
        test_reset();
        test_sat_neg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
